// File: rtl/uart_tx_serialiser.sv
// UART transmit serialiser: start bit, LSB-first data, optional parity, 1-2 stop bits,
// with a one-entry holding buffer so the next byte can be queued mid-frame.
module uart_tx_serialiser #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_WIDTH   = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_start_i,
  output logic                  tx_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  overrun_o,
  output logic [2:0]            state_o
);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic             ODD       = (PARITY_ODD != 0);

  state_t                  state;
  logic [CNT_W-1:0]        baud_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [DATA_WIDTH-1:0]   shift;
  logic                    parity_bit;
  logic [DATA_WIDTH-1:0]   buf_data;
  logic                    buf_valid;

  logic                    bit_end;
  logic                    frame_end;
  logic [DATA_WIDTH-1:0]   load_data;

  // tx_start_i is a strobe with no ready: a start that finds the buffer full is
  // dropped and reported on overrun_o; otherwise it is always accepted.
  assign bit_end   = (baud_cnt == CNT_LAST);
  assign frame_end = (state == STOP) && bit_end && (bit_cnt == STOP_LAST);
  assign load_data = (state != IDLE && buf_valid) ? buf_data : tx_data_i;
  assign state_o   = state;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      buf_data   <= '0;
      buf_valid  <= 1'b0;
      tx_o       <= 1'b1;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      overrun_o  <= 1'b0;
    end else begin
      done_o    <= 1'b0;
      overrun_o <= 1'b0;
      if (state != IDLE) baud_cnt <= bit_end ? '0 : baud_cnt + CNT_W'(1);

      case (state)
        IDLE: if (tx_start_i) begin
          shift      <= tx_data_i;
          parity_bit <= (^tx_data_i) ^ ODD;
          bit_cnt    <= '0;
          state      <= START;
          tx_o       <= 1'b0;
          busy_o     <= 1'b1;
        end
        START: if (bit_end) begin
          state <= DATA;
          tx_o  <= shift[0];
        end
        DATA: if (bit_end) begin
          shift <= shift >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_cnt <= '0;
            if (PARITY_EN != 0) begin
              state <= PARITY;
              tx_o  <= parity_bit;
            end else begin
              state <= STOP;
              tx_o  <= 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            tx_o    <= shift[1];
          end
        end
        PARITY: if (bit_end) begin
          state <= STOP;
          tx_o  <= 1'b1;
        end
        STOP: if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            done_o  <= 1'b1;
            bit_cnt <= '0;
            // A same-cycle strobe with an empty buffer goes straight on the line.
            if (buf_valid || tx_start_i) begin
              shift      <= load_data;
              parity_bit <= (^load_data) ^ ODD;
              state      <= START;
              tx_o       <= 1'b0;
            end else begin
              state  <= IDLE;
              busy_o <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase

      if (frame_end) begin
        buf_valid <= buf_valid && tx_start_i;
        if (tx_start_i) buf_data <= tx_data_i;
      end else if (state != IDLE && tx_start_i) begin
        if (!buf_valid) begin
          buf_data  <= tx_data_i;
          buf_valid <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_serialiser.sv
// Bench for uart_tx_serialiser: three configurations driven by one stimulus stream,
// each checked every cycle against a frame-waveform model, plus literal waveform checks.
module tb_uart_tx_serialiser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] tx_data = '0;
  logic       tx_start = 1'b0;

  logic [2:0] tx_w, busy_w, done_w, ovr_w;
  logic [2:0] st_a, st_b, st_c;

  always #5 clk = ~clk;

  uart_tx_serialiser #(.CLKS_PER_BIT(4), .DATA_WIDTH(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_a (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_start_i(tx_start),
    .tx_o(tx_w[0]), .busy_o(busy_w[0]), .done_o(done_w[0]), .overrun_o(ovr_w[0]), .state_o(st_a));
  uart_tx_serialiser #(.CLKS_PER_BIT(4), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_start_i(tx_start),
    .tx_o(tx_w[1]), .busy_o(busy_w[1]), .done_o(done_w[1]), .overrun_o(ovr_w[1]), .state_o(st_b));
  uart_tx_serialiser #(.CLKS_PER_BIT(2), .DATA_WIDTH(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_c (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_start_i(tx_start),
    .tx_o(tx_w[2]), .busy_o(busy_w[2]), .done_o(done_w[2]), .overrun_o(ovr_w[2]), .state_o(st_c));

  // configuration of each instance, as seen by the model
  int cpb[3]   = '{4, 4, 2};
  int pen[3]   = '{0, 1, 1};
  int podd[3]  = '{0, 0, 1};
  int nstop[3] = '{1, 2, 1};

  // model: the expected frame as a bit list, and the cycle position within it
  logic [15:0] frame[3];
  int          flen[3];
  int          pos[3];
  bit          act[3];
  bit          bv[3];
  logic [7:0]  bd[3];
  bit          e_tx[3], e_busy[3], e_done[3], e_ovr[3];
  bit          model_ok = 1'b0;
  bit          rx_flush = 1'b0;

  logic [7:0]  exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;

  int          done_cnt = 0, ovr_cnt = 0;
  bit          cnt_en = 1'b0;

  bit          rx_busy = 1'b0, rx_prev = 1'b1;
  int          rx_cnt = 0;
  logic [7:0]  rx_byte = '0;

  logic cap_tx_a[64], cap_done_a[64], cap_busy_a[64];
  logic cap_tx_b[64], cap_done_b[64], cap_tx_c[64], cap_done_c[64];

  task automatic check(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void start_frame(int i, logic [7:0] d);
    int n;
    frame[i] = '0;
    frame[i][0] = 1'b0;
    n = 1;
    for (int k = 0; k < 8; k++) begin
      frame[i][n] = d[k];
      n++;
    end
    if (pen[i] != 0) begin
      frame[i][n] = (^d) ^ (podd[i] != 0);
      n++;
    end
    for (int s = 0; s < nstop[i]; s++) begin
      frame[i][n] = 1'b1;
      n++;
    end
    flen[i] = n;
    pos[i]  = 0;
    act[i]  = 1'b1;
    if (i == 0) exp_q.push_back(d);
  endfunction

  // reference model, advanced on every active edge
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit was_idle, fend;
      if (!rst_n) begin
        act[i]    = 1'b0;
        bv[i]     = 1'b0;
        e_done[i] = 1'b0;
        e_ovr[i]  = 1'b0;
        if (i == 0) begin
          exp_q.delete();
          rx_flush = 1'b1;
        end
      end else begin
        was_idle = !act[i];
        fend     = 1'b0;
        if (act[i]) begin
          pos[i]++;
          if (pos[i] == flen[i] * cpb[i]) begin
            act[i] = 1'b0;
            fend   = 1'b1;
          end
        end
        e_done[i] = fend;
        e_ovr[i]  = 1'b0;
        if (tx_start) begin
          if (was_idle) start_frame(i, tx_data);
          else if (fend) begin
            if (bv[i]) begin
              start_frame(i, bd[i]);
              bd[i] = tx_data;
            end else begin
              start_frame(i, tx_data);
            end
          end else if (!bv[i]) begin
            bv[i] = 1'b1;
            bd[i] = tx_data;
          end else begin
            e_ovr[i] = 1'b1;
          end
        end else if (fend && bv[i]) begin
          start_frame(i, bd[i]);
          bv[i] = 1'b0;
        end
      end
      e_tx[i]   = act[i] ? frame[i][pos[i] / cpb[i]] : 1'b1;
      e_busy[i] = act[i] | bv[i];
    end
    model_ok = 1'b1;
  end

  // compare process
  always @(negedge clk) begin
    if (model_ok) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("tx%0d", i), tx_w[i], e_tx[i]);
        check($sformatf("busy%0d", i), busy_w[i], e_busy[i]);
        check($sformatf("done%0d", i), done_w[i], e_done[i]);
        check($sformatf("overrun%0d", i), ovr_w[i], e_ovr[i]);
      end
    end
  end

  // line receiver on instance 0 (4 clocks per bit): decodes bytes and scores them
  always @(negedge clk) begin
    if (rx_flush) begin
      rx_busy  = 1'b0;
      rx_prev  = 1'b1;
      rx_flush = 1'b0;
    end else if (model_ok) begin
      if (!rx_busy) begin
        if (rx_prev && !tx_w[0]) begin
          rx_busy = 1'b1;
          rx_cnt  = 0;
        end
      end else begin
        rx_cnt++;
        if (rx_cnt >= 6 && rx_cnt <= 34 && ((rx_cnt - 6) % 4) == 0)
          rx_byte[(rx_cnt - 6) / 4] = tx_w[0];
        if (rx_cnt == 38) begin
          check("rx_stop", tx_w[0], 1'b1);
          if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL rx_byte: got %h expected none at %0t", rx_byte, $time);
          end else begin
            check_byte("rx_byte", rx_byte, exp_q.pop_front());
          end
          rx_busy = 1'b0;
        end
      end
      rx_prev = tx_w[0];
    end
  end

  always @(negedge clk) begin
    if (cnt_en) begin
      done_cnt += int'(done_w[0]);
      ovr_cnt  += int'(ovr_w[0]);
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic capture();
    for (int k = 0; k < 64; k++) begin
      cap_tx_a[k]   = tx_w[0];
      cap_done_a[k] = done_w[0];
      cap_busy_a[k] = busy_w[0];
      cap_tx_b[k]   = tx_w[1];
      cap_done_b[k] = done_w[1];
      cap_tx_c[k]   = tx_w[2];
      cap_done_c[k] = done_w[2];
      @(negedge clk);
    end
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    wait_cycles(3);
    check("reset_tx_a", tx_w[0], 1'b1);
    check("reset_busy_a", busy_w[0], 1'b0);
    check("reset_done_a", done_w[0], 1'b0);
    check("reset_ovr_a", ovr_w[0], 1'b0);
    check("reset_tx_b", tx_w[1], 1'b1);
    check("reset_tx_c", tx_w[2], 1'b1);
    rst_n = 1'b1;
    wait_cycles(2);

    // basic frame 0xA5 on the 4-clock, no-parity, 1-stop instance
    strobe(8'hA5);
    capture();
    check("a5_start0", cap_tx_a[0], 1'b0);
    check("a5_start3", cap_tx_a[3], 1'b0);
    check("a5_bit0", cap_tx_a[4], 1'b1);
    check("a5_bit1", cap_tx_a[8], 1'b0);
    check("a5_bit2", cap_tx_a[12], 1'b1);
    check("a5_bit4", cap_tx_a[20], 1'b0);
    check("a5_bit5", cap_tx_a[24], 1'b1);
    check("a5_bit7", cap_tx_a[32], 1'b1);
    check("a5_stop", cap_tx_a[36], 1'b1);
    check("a5_busy_first", cap_busy_a[0], 1'b1);
    check("a5_done_early", cap_done_a[39], 1'b0);
    check("a5_done_at40", cap_done_a[40], 1'b1);
    check("a5_done_after", cap_done_a[41], 1'b0);
    check("a5_busy_end", cap_busy_a[40], 1'b0);

    // 0x07: even parity + 2 stops (instance b), odd parity at 2 clocks/bit (instance c)
    strobe(8'h07);
    capture();
    check("p07_b_bit7", cap_tx_b[32], 1'b0);
    check("p07_b_parity", cap_tx_b[36], 1'b1);
    check("p07_b_stop1", cap_tx_b[40], 1'b1);
    check("p07_b_stop2_end", cap_tx_b[47], 1'b1);
    check("p07_b_done_early", cap_done_b[47], 1'b0);
    check("p07_b_done", cap_done_b[48], 1'b1);
    check("p07_c_bit7", cap_tx_c[16], 1'b0);
    check("p07_c_parity", cap_tx_c[18], 1'b0);
    check("p07_c_stop", cap_tx_c[20], 1'b1);
    check("p07_c_done_early", cap_done_c[21], 1'b0);
    check("p07_c_done", cap_done_c[22], 1'b1);

    // back-to-back via the holding buffer
    done_cnt = 0;
    ovr_cnt  = 0;
    cnt_en   = 1'b1;
    strobe(8'h11);
    wait_cycles(10);
    strobe(8'h22);
    wait_cycles(100);
    cnt_en = 1'b0;
    check_int("b2b_done_count", done_cnt, 2);
    check_int("b2b_overrun_count", ovr_cnt, 0);

    // overrun: third strobe within the first frame is dropped
    done_cnt = 0;
    ovr_cnt  = 0;
    cnt_en   = 1'b1;
    strobe(8'h11);
    wait_cycles(3);
    strobe(8'h22);
    wait_cycles(3);
    strobe(8'h33);
    check("ovr_pulse", ovr_w[0], 1'b1);
    wait_cycles(100);
    cnt_en = 1'b0;
    check_int("ovr_done_count", done_cnt, 2);
    check_int("ovr_overrun_count", ovr_cnt, 1);

    // reset during data bit 3 with a byte waiting in the buffer
    strobe(8'hC3);
    wait_cycles(2);
    strobe(8'h99);
    wait_cycles(14);
    rst_n = 1'b0;
    wait_cycles(1);
    check("midrst_tx_a", tx_w[0], 1'b1);
    check("midrst_busy_a", busy_w[0], 1'b0);
    check("midrst_busy_b", busy_w[1], 1'b0);
    rst_n = 1'b1;
    wait_cycles(5);
    check("postrst_busy_a", busy_w[0], 1'b0);
    strobe(8'h5A);
    check("postrst_start", tx_w[0], 1'b0);
    wait_cycles(60);

    // strobe exactly on the final stop-bit end with the buffer empty
    strobe(8'h81);
    t = 0;
    while (!(act[0] && !bv[0] && pos[0] == flen[0] * cpb[0] - 1) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("boundary_wait_timeout", t < 200, 1'b1);
    strobe(8'h3C);
    check("boundary_tx", tx_w[0], 1'b0);
    check("boundary_done", done_w[0], 1'b1);
    check("boundary_ovr", ovr_w[0], 1'b0);
    check("boundary_busy", busy_w[0], 1'b1);
    wait_cycles(60);

    // random traffic with occasional resets
    for (int n = 0; n < 400; n++) begin
      wait_cycles($urandom_range(0, 25));
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        wait_cycles($urandom_range(1, 3));
        rst_n = 1'b1;
      end
      strobe(8'($urandom_range(0, 255)));
    end

    wait_cycles(150);
    check_int("final_exp_q_empty", exp_q.size(), 0);
    check("final_rx_idle", rx_busy, 1'b0);
    check("final_busy_a", busy_w[0], 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
